// File: rtl/state_polyfrommsg__masked_encode_rng_core.sv
// Three-lane xorshift32 generator for masked message encoding: collects a
// 3-word seed, whitens it against fixed constants, warms up, then streams shares.
module state_polyfrommsg__masked_encode_rng_core #(
    parameter int COEFF_SZ = 16,
    parameter int WARMUP   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seed_valid,
    input  logic [2*COEFF_SZ-1:0] seed,
    output logic                  seed_ready,
    input  logic                  reseed,
    input  logic                  rnd_ready,
    output logic                  rnd_valid,
    output logic [COEFF_SZ-1:0]   r1,
    output logic [COEFF_SZ-1:0]   r2,
    output logic [COEFF_SZ-1:0]   r3,
    output logic [COEFF_SZ-1:0]   r4,
    output logic [COEFF_SZ-1:0]   r5,
    output logic [COEFF_SZ-1:0]   r6
);

    localparam int LANE_W = 2 * COEFF_SZ;
    localparam logic [LANE_W-1:0] K0 = LANE_W'(32'h70c21021);
    localparam logic [LANE_W-1:0] K1 = LANE_W'(32'h81e06c70);
    localparam logic [LANE_W-1:0] K2 = LANE_W'(32'h50b210bd);
    localparam logic [3:0] WARM_LAST = 4'(WARMUP - 1);

    typedef enum logic [1:0] {COLLECT, LOAD, WARM, RUN} state_t;

    state_t            state_q, state_d;
    logic [1:0]        word_cnt_q;
    logic [3:0]        warm_cnt_q;
    logic              rnd_valid_q;
    logic [LANE_W-1:0] seed_buf_q [3];
    logic [LANE_W-1:0] lane_q     [3];
    logic              seed_fire;
    logic              consume;

    function automatic logic [LANE_W-1:0] xs_step(input logic [LANE_W-1:0] x);
        logic [LANE_W-1:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // A zero lane would lock xorshift at zero forever, so fall back to the constant.
    function automatic logic [LANE_W-1:0] whiten(input logic [LANE_W-1:0] k,
                                                 input logic [LANE_W-1:0] w);
        logic [LANE_W-1:0] t;
        t = k ^ w;
        return (t == '0) ? k : t;
    endfunction

    assign seed_fire = seed_valid && seed_ready && !reseed;
    assign consume   = (state_q == RUN) && rnd_valid_q && rnd_ready && !reseed;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        seed_ready = (state_q == COLLECT);
        case (state_q)
            COLLECT: if (seed_fire && word_cnt_q == 2'd2) state_d = LOAD;
            LOAD:    state_d = (WARMUP == 0) ? RUN : WARM;
            WARM:    if (warm_cnt_q == WARM_LAST) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = COLLECT;
        endcase
        if (reseed) state_d = COLLECT;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values. The seed buffers and lanes are ordinary flops here and
    // are reset explicitly; they are not mapped to a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            word_cnt_q  <= '0;
            warm_cnt_q  <= '0;
            rnd_valid_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                seed_buf_q[i] <= '0;
                lane_q[i]     <= '0;
            end
        end else begin
            state_q     <= state_d;
            rnd_valid_q <= (state_q == RUN) && !reseed;

            if (reseed) begin
                word_cnt_q <= '0;
            end else if (seed_fire) begin
                for (int i = 0; i < 3; i++)
                    if (word_cnt_q == 2'(i)) seed_buf_q[i] <= seed;
                word_cnt_q <= (word_cnt_q == 2'd2) ? 2'd0 : word_cnt_q + 2'd1;
            end

            if (state_q == LOAD)      warm_cnt_q <= '0;
            else if (state_q == WARM) warm_cnt_q <= warm_cnt_q + 4'd1;

            // Lanes only move on load, warm-up or a real consumption; reseed freezes them.
            if (!reseed) begin
                if (state_q == LOAD) begin
                    lane_q[0] <= whiten(K0, seed_buf_q[0]);
                    lane_q[1] <= whiten(K1, seed_buf_q[1]);
                    lane_q[2] <= whiten(K2, seed_buf_q[2]);
                end else if (state_q == WARM || consume) begin
                    for (int i = 0; i < 3; i++) lane_q[i] <= xs_step(lane_q[i]);
                end
            end
        end
    end

    assign rnd_valid = rnd_valid_q;
    assign r1 = lane_q[0][LANE_W-1:COEFF_SZ];
    assign r4 = lane_q[0][COEFF_SZ-1:0];
    assign r2 = lane_q[1][LANE_W-1:COEFF_SZ];
    assign r5 = lane_q[1][COEFF_SZ-1:0];
    assign r3 = lane_q[2][LANE_W-1:COEFF_SZ];
    assign r6 = lane_q[2][COEFF_SZ-1:0];

endmodule

// File: tb/tb_state_polyfrommsg__masked_encode_rng_core.sv
// Scoreboard bench: two instances (WARMUP=1 and WARMUP=0) share stimulus; a
// monitor pops expected samples on every consumption.
module tb_state_polyfrommsg__masked_encode_rng_core;

    localparam logic [31:0] K0 = 32'h70c21021;
    localparam logic [31:0] K1 = 32'h81e06c70;
    localparam logic [31:0] K2 = 32'h50b210bd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_valid = 1'b0;
    logic [31:0] seed = '0;
    logic        reseed = 1'b0;
    logic        rnd_ready = 1'b0;

    logic        a_seed_ready, a_rnd_valid, b_seed_ready, b_rnd_valid;
    logic [15:0] a_r1, a_r2, a_r3, a_r4, a_r5, a_r6;
    logic [15:0] b_r1, b_r2, b_r3, b_r4, b_r5, b_r6;

    int n_checks = 0;
    int n_errors = 0;
    int cons_a = 0;
    int cons_b = 0;
    logic [95:0] q_a[$];
    logic [95:0] q_b[$];

    always #5 clk = ~clk;

    state_polyfrommsg__masked_encode_rng_core #(.COEFF_SZ(16), .WARMUP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed),
        .seed_ready(a_seed_ready), .reseed(reseed), .rnd_ready(rnd_ready),
        .rnd_valid(a_rnd_valid), .r1(a_r1), .r2(a_r2), .r3(a_r3),
        .r4(a_r4), .r5(a_r5), .r6(a_r6)
    );

    state_polyfrommsg__masked_encode_rng_core #(.COEFF_SZ(16), .WARMUP(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed),
        .seed_ready(b_seed_ready), .reseed(reseed), .rnd_ready(rnd_ready),
        .rnd_valid(b_rnd_valid), .r1(b_r1), .r2(b_r2), .r3(b_r3),
        .r4(b_r4), .r5(b_r5), .r6(b_r6)
    );

    function automatic logic [95:0] smp_a();
        return {a_r1, a_r4, a_r2, a_r5, a_r3, a_r6};
    endfunction

    function automatic logic [95:0] smp_b();
        return {b_r1, b_r4, b_r2, b_r5, b_r3, b_r6};
    endfunction

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [31:0] xs_n(input logic [31:0] x, input int n);
        logic [31:0] t;
        t = x;
        for (int i = 0; i < n; i++) t = xs(t);
        return t;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        seed       = w;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
    endtask

    // Expected stream for freshly loaded lanes l0..l2: instance A has already
    // warmed one step, instance B presents the loaded lanes directly.
    task automatic push_stream(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2);
        q_a.delete();
        q_b.delete();
        for (int n = 0; n < 8; n++) begin
            q_a.push_back({xs_n(l0, n + 1), xs_n(l1, n + 1), xs_n(l2, n + 1)});
            q_b.push_back({xs_n(l0, n), xs_n(l1, n), xs_n(l2, n)});
        end
    endtask

    // Edges from the accepting edge of word 2 until rnd_valid; 0 means never.
    task automatic wait_valid(input string tag, input int exp_a, input int exp_b);
        int la;
        int lb;
        la = 0;
        lb = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (a_rnd_valid && la == 0) la = k;
            if (b_rnd_valid && lb == 0) lb = k;
            if (la != 0 && lb != 0) break;
        end
        check({tag, "_latency_a"}, 96'(la), 96'(exp_a));
        check({tag, "_latency_b"}, 96'(lb), 96'(exp_b));
    endtask

    // Monitor: a consumption is valid & ready without a simultaneous reseed.
    always @(negedge clk) begin
        if (rst_n && rnd_ready && !reseed) begin
            if (a_rnd_valid) begin
                cons_a++;
                if (q_a.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_a_underflow: got %h expected none", smp_a());
                end else begin
                    check("sb_a", smp_a(), q_a.pop_front());
                end
            end
            if (b_rnd_valid) begin
                cons_b++;
                if (q_b.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_b_underflow: got %h expected none", smp_b());
                end else begin
                    check("sb_b", smp_b(), q_b.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check("rst_out_a", smp_a(), '0);
        check("rst_out_b", smp_b(), '0);
        check("rst_valid", 96'({a_rnd_valid, b_rnd_valid}), 96'(2'b00));
        check("rst_ready", 96'({a_seed_ready, b_seed_ready}), 96'(2'b11));
        tick();
        rst_n = 1'b1;
        tick();

        // All lanes load 1; gaps between seed words
        send_word(32'h70c21020);
        tick();
        send_word(32'h81e06c71);
        tick();
        tick();
        send_word(32'h50b210bc);
        check("ready_after_w2", 96'({a_seed_ready, b_seed_ready}), 96'(2'b00));
        wait_valid("ones", 3, 2);
        check("ones_a", smp_a(), 96'h00042021_00042021_00042021);
        check("ones_b", smp_b(), 96'h00000001_00000001_00000001);
        repeat (10) tick();
        check("hold_a", smp_a(), 96'h00042021_00042021_00042021);
        check("hold_b", smp_b(), 96'h00000001_00000001_00000001);
        check("hold_valid", 96'({a_rnd_valid, b_rnd_valid}), 96'(2'b11));
        push_stream(32'h1, 32'h1, 32'h1);
        rnd_ready = 1'b1;
        repeat (5) tick();
        rnd_ready = 1'b0;

        // Reseed from RUN, then reseed again after word 1 of a new seed
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
        check("reseed_valid", 96'({a_rnd_valid, b_rnd_valid}), 96'(2'b00));
        check("reseed_ready", 96'({a_seed_ready, b_seed_ready}), 96'(2'b11));
        send_word(32'h12345678);
        tick();
        send_word(32'h9abcdef0);
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
        send_word(K0);
        tick();
        send_word(K1 ^ 32'h1);
        check("restart_ready", 96'({a_seed_ready, b_seed_ready}), 96'(2'b11));
        check("restart_valid", 96'({a_rnd_valid, b_rnd_valid}), 96'(2'b00));
        send_word(K2 ^ 32'h2);
        wait_valid("zero", 3, 2);
        check("zero_lane_b", smp_b(), {K0, 32'h1, 32'h2});
        check("zero_lane_a", smp_a(), {xs(K0), xs(32'h1), xs(32'h2)});
        push_stream(K0, 32'h1, 32'h2);
        rnd_ready = 1'b1;
        repeat (3) tick();
        rnd_ready = 1'b0;

        // Reseed coinciding with a seed transfer, then with a consumption
        reseed = 1'b1;
        tick();
        reseed = 1'b0;
        send_word(K0 ^ 32'h3);
        seed       = 32'hdeadbeef;
        seed_valid = 1'b1;
        reseed     = 1'b1;
        tick();
        seed_valid = 1'b0;
        reseed     = 1'b0;
        send_word(K0 ^ 32'h3);
        tick();
        send_word(K1 ^ 32'h4);
        check("drop_ready", 96'({a_seed_ready, b_seed_ready}), 96'(2'b11));
        send_word(K2 ^ 32'h5);
        wait_valid("drop", 3, 2);
        check("drop_a", smp_a(), {xs(32'h3), xs(32'h4), xs(32'h5)});
        check("drop_b", smp_b(), {32'h3, 32'h4, 32'h5});
        rnd_ready = 1'b1;
        reseed    = 1'b1;
        tick();
        rnd_ready = 1'b0;
        reseed    = 1'b0;
        check("rs_cons_valid", 96'({a_rnd_valid, b_rnd_valid}), 96'(2'b00));
        check("rs_cons_ready", 96'({a_seed_ready, b_seed_ready}), 96'(2'b11));
        check("rs_cons_a", smp_a(), {xs(32'h3), xs(32'h4), xs(32'h5)});
        check("rs_cons_b", smp_b(), {32'h3, 32'h4, 32'h5});

        // Reset pulse during RUN
        send_word(32'h70c21020);
        send_word(32'h81e06c71);
        send_word(32'h50b210bc);
        wait_valid("prerst", 3, 2);
        push_stream(32'h1, 32'h1, 32'h1);
        rnd_ready = 1'b1;
        repeat (2) tick();
        rnd_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("runrst_out_a", smp_a(), '0);
        check("runrst_out_b", smp_b(), '0);
        check("runrst_valid", 96'({a_rnd_valid, b_rnd_valid}), 96'(2'b00));
        check("runrst_ready", 96'({a_seed_ready, b_seed_ready}), 96'(2'b11));
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-collection discards the partial word
        send_word(32'h11111111);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_word(32'h70c21020);
        send_word(32'h81e06c71);
        send_word(32'h50b210bc);
        wait_valid("postrst", 3, 2);
        check("postrst_a", smp_a(), 96'h00042021_00042021_00042021);
        check("postrst_b", smp_b(), 96'h00000001_00000001_00000001);
        push_stream(32'h1, 32'h1, 32'h1);
        rnd_ready = 1'b1;
        repeat (2) tick();
        rnd_ready = 1'b0;
        tick();

        check("consumed_a", 96'(cons_a), 96'(12));
        check("consumed_b", 96'(cons_b), 96'(12));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/state_polyfrommsg__masked_encode_rng_core.md
STATE_POLYFROMMSG__MASKED_ENCODE_RNG_CORE -- requirements
Module: State_Polyfrommsg__masked_encode_RNG_core

Interface
REQ-001 SHALL have parameter COEFF_SZ, default 16, width of each random output; lane width is 2*COEFF_SZ = 32.
REQ-002 SHALL have parameter WARMUP, default 4, number of discard steps after load (legal 0..15).
REQ-003 SHALL use one clock and an asynchronous active-low reset, fixed as follows:
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 seed_valid  in  1  seed word offered.
REQ-007 seed  in  32  seed word.
REQ-008 seed_ready  out  1  block accepts a seed word; transfer occurs when seed_valid & seed_ready.
REQ-009 reseed  in  1  abandon the current state and restart seed collection.
REQ-010 rnd_ready  in  1  consumer takes the current randoms.
REQ-011 rnd_valid  out  1  r1..r6 hold valid, unconsumed randoms.
REQ-012 r1..r6  out  COEFF_SZ each  random mask shares.

Function
REQ-013 SHALL implement states COLLECT, LOAD, WARM, RUN; the state after reset is COLLECT.
REQ-014 COLLECT: seed_ready=1, and a 2-bit counter indexes accepted words 0,1,2; word i is stored in seed buffer i.
REQ-015 On the transfer of word 2: the counter clears and the next state is LOAD; seed_ready=0 in every state except COLLECT.
REQ-016 LOAD (1 cycle): lane i <= K_i ^ word i, with K0=0x70c21021, K1=0x81e06c70, K2=0x50b210bd.
REQ-017 If K_i ^ word i == 0, lane i SHALL load K_i instead; a lane SHALL never hold zero outside reset.
REQ-018 Step function per 32-bit lane: x ^= x<<13; x ^= x>>17; x ^= x<<5, all shifts logical and truncated to 32 bits.
REQ-019 WARM: all three lanes step once per cycle for WARMUP cycles, then go to RUN; WARMUP=0 SHALL go from LOAD directly to RUN.
REQ-020 RUN: rnd_valid=1; r1,r4 = lane0[31:16],[15:0]; r2,r5 = lane1[31:16],[15:0]; r3,r6 = lane2[31:16],[15:0].
REQ-021 In RUN, lanes SHALL step on a cycle exactly when rnd_valid & rnd_ready, so a new sample is presented the following cycle; with rnd_ready held high, throughput is one sample per cycle.
REQ-022 With rnd_ready=0, lanes and outputs SHALL hold unchanged.
REQ-023 Latency: rnd_valid SHALL rise WARMUP+2 rising edges after the edge that accepts word 2.
REQ-024 r1..r6 SHALL equal the lane bits in every state; rnd_valid=0 outside RUN.
REQ-025 reseed=1 in any state SHALL force COLLECT next cycle, clear the word counter, and drop rnd_valid; lanes hold until the next LOAD.
REQ-026 If reseed and a seed transfer coincide in COLLECT, reseed SHALL win: the word is dropped and the counter is 0.
REQ-027 If reseed and a consumption (rnd_ready) coincide in RUN, lanes SHALL NOT step.

Reset
REQ-028 On rst_n=0, asynchronously: state=COLLECT, counter=0, lanes=0, seed buffers=0, rnd_valid=0, r1..r6=0, seed_ready=1 (seed_ready is decoded from state).
REQ-029 Reset mid-collection or in RUN SHALL discard all partial seed words; operation after release SHALL be identical to operation from power-up.

Verification
REQ-030 WARMUP=1; seeds 0x70c21020, 0x81e06c71, 0x50b210bc (all lanes=1) -> rnd_valid 3 edges after word 2; r1=r2=r3=0x0004; r4=r5=r6=0x2021.
REQ-031 Same as REQ-030 with rnd_ready=0 for 10 cycles, then 1 -> outputs stable for 10 cycles, then lanes step once per cycle; first stepped value matches a software xorshift model.
REQ-032 Seed word0 = 0x70c21021 (zero case) -> lane0 loads 0x70c21021, and with WARMUP=0, r1=0x70c2 and r4=0x1021 on the first rnd_valid.
REQ-033 seed_valid toggling 1/0 with gaps, plus reseed asserted after word 1 -> collection restarts, 3 fresh words required, and no rnd_valid in between.
REQ-034 rst_n pulsed low for 1 cycle during RUN -> all outputs 0 immediately and seed_ready=1; a reseed-free resend of the same seeds reproduces the same first sample.
REQ-035 Simultaneous reseed and seed transfer, and simultaneous reseed and rnd_ready -> the word is dropped, lanes are not stepped, and state is COLLECT.
